// File: rtl/multi_channel_clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable divider.
// Holds the channel-count ceiling, the default counter width and the
// channel-select width function used by the top-level load port.
package multi_channel_clock_divider_pkg;

    // Largest supported number of divider channels.
    localparam int CLOCK_DIVIDER_MAX_CHANNELS  = 16;

    // Default counter/divisor width in bits.
    localparam int CLOCK_DIVIDER_DEFAULT_WIDTH = 32;

    // Width of the channel-select field; never narrower than one bit so a
    // single-channel build still has a legal port.
    function automatic int ch_sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/multi_channel_clock_divider_channel.sv
// One divider channel: free-running counter, active and shadow divisors,
// pending flag and a registered single-cycle tick output.
// The shadow divisor is only promoted to active on a wrap, while the channel
// is disabled, or on a phase sync, so a ratio change never cuts a period short.
module divider_channel
    import multi_channel_clock_divider_pkg::*;
#(
    parameter int p_WIDTH       = CLOCK_DIVIDER_DEFAULT_WIDTH,
    parameter int p_DEFAULT_DIV = 3
) (
    input  logic               i_CLK,
    input  logic               i_RESET_N,
    input  logic               i_ENABLE,
    input  logic               i_LOAD,
    input  logic               i_SYNC,
    input  logic [p_WIDTH-1:0] i_DIV_VALUE,
    output logic               o_ENABLE_OUT,
    output logic               o_PENDING
);

    localparam logic [p_WIDTH-1:0] DEFAULT_DIV = p_WIDTH'(p_DEFAULT_DIV);

    logic [p_WIDTH-1:0] count_q, count_d;
    logic [p_WIDTH-1:0] active_q, active_d;
    logic [p_WIDTH-1:0] shadow_q, shadow_d;
    logic               pending_q, pending_d;
    logic               tick_q, tick_d;
    logic               wrap;
    logic               apply;

    // Next-state logic: count/wrap, shadow-to-active apply, shadow load.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        count_d   = count_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        tick_d    = 1'b0;

        // Wrap is tested with >= so a shrinking divisor can never strand the
        // counter above it, and it takes priority over the increment so the
        // all-ones divisor cannot overflow.
        wrap  = i_ENABLE && (count_q >= active_q);
        apply = i_SYNC || !i_ENABLE || wrap;

        if (i_SYNC || !i_ENABLE) begin
            count_d = '0;
        end else if (wrap) begin
            count_d = '0;
            tick_d  = (count_q == active_q);
        end else begin
            count_d = count_q + p_WIDTH'(1);
        end

        if (apply) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        // A load in the same cycle as an apply still lands in the shadow: the
        // apply above consumed the old shadow value, the new one stays pending.
        if (i_LOAD) begin
            shadow_d  = i_DIV_VALUE;
            pending_d = 1'b1;
        end
    end

    // State registers; reset discards any pending load.
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            count_q   <= '0;
            active_q  <= DEFAULT_DIV;
            shadow_q  <= DEFAULT_DIV;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            count_q   <= count_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
        end
    end

    assign o_ENABLE_OUT = tick_q;
    assign o_PENDING    = pending_q;

endmodule

// File: rtl/multi_channel_clock_divider.sv
// Multi-channel clock-enable divider: p_CHANNELS independent tick generators
// with runtime-programmable divisors written through a shadow-register port.
// Optional build macro CLOCK_DIVIDER_PHASE_SYNC_EN adds i_SYNC, which zeroes
// every counter and applies all pending divisors so equal-ratio channels
// line up in phase.
module multi_channel_clock_divider
    import multi_channel_clock_divider_pkg::*;
#(
    parameter int p_CHANNELS    = 4,
    parameter int p_WIDTH       = CLOCK_DIVIDER_DEFAULT_WIDTH,
    parameter int p_DEFAULT_DIV = 3
) (
    input  logic                                  i_CLK,
    input  logic                                  i_RESET_N,
`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
    input  logic                                  i_SYNC,
`endif
    input  logic [p_CHANNELS-1:0]                 i_ENABLE,
    input  logic                                  i_LOAD,
    input  logic [ch_sel_width(p_CHANNELS)-1:0]   i_CH_SEL,
    input  logic [p_WIDTH-1:0]                    i_DIV_VALUE,
    output logic [p_CHANNELS-1:0]                 o_ENABLE_OUT,
    output logic [p_CHANNELS-1:0]                 o_PENDING
);

    localparam int SEL_W = ch_sel_width(p_CHANNELS);

    logic                  sync;
    logic [p_CHANNELS-1:0] load_sel;

`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
    assign sync = i_SYNC;
`else
    assign sync = 1'b0;
`endif

    // Load decode: a select value beyond the last channel matches nothing,
    // so an out-of-range load leaves every channel untouched.
    always_comb begin
        load_sel = '0;
        for (int c = 0; c < p_CHANNELS; c++) begin
            load_sel[c] = i_LOAD && (i_CH_SEL == SEL_W'(c));
        end
    end

    for (genvar c = 0; c < p_CHANNELS; c++) begin : g_ch
        divider_channel #(
            .p_WIDTH       (p_WIDTH),
            .p_DEFAULT_DIV (p_DEFAULT_DIV)
        ) u_ch (
            .i_CLK        (i_CLK),
            .i_RESET_N    (i_RESET_N),
            .i_ENABLE     (i_ENABLE[c]),
            .i_LOAD       (load_sel[c]),
            .i_SYNC       (sync),
            .i_DIV_VALUE  (i_DIV_VALUE),
            .o_ENABLE_OUT (o_ENABLE_OUT[c]),
            .o_PENDING    (o_PENDING[c])
        );
    end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Directed testbench for multi_channel_clock_divider.
// Main instance: 4 channels, 32-bit. Second instance: 3 channels, 4-bit, used
// for the out-of-range select and the all-ones divisor.
// Build with CLOCK_DIVIDER_PHASE_SYNC_EN defined to include the sync scenario.
module tb_multi_channel_clock_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync;
    logic [3:0]  en;
    logic        load;
    logic [1:0]  ch_sel;
    logic [31:0] div;
    logic [3:0]  out;
    logic [3:0]  pend;

    logic [2:0]  b_en;
    logic        b_load;
    logic [1:0]  b_sel;
    logic [3:0]  b_div;
    logic [2:0]  b_out;
    logic [2:0]  b_pend;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multi_channel_clock_divider #(
        .p_CHANNELS    (4),
        .p_WIDTH       (32),
        .p_DEFAULT_DIV (3)
    ) u_dut (
        .i_CLK        (clk),
        .i_RESET_N    (rst_n),
`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
        .i_SYNC       (sync),
`endif
        .i_ENABLE     (en),
        .i_LOAD       (load),
        .i_CH_SEL     (ch_sel),
        .i_DIV_VALUE  (div),
        .o_ENABLE_OUT (out),
        .o_PENDING    (pend)
    );

    multi_channel_clock_divider #(
        .p_CHANNELS    (3),
        .p_WIDTH       (4),
        .p_DEFAULT_DIV (3)
    ) u_dut_b (
        .i_CLK        (clk),
        .i_RESET_N    (rst_n),
`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
        .i_SYNC       (1'b0),
`endif
        .i_ENABLE     (b_en),
        .i_LOAD       (b_load),
        .i_CH_SEL     (b_sel),
        .i_DIV_VALUE  (b_div),
        .o_ENABLE_OUT (b_out),
        .o_PENDING    (b_pend)
    );

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with all inputs idle; returns on a falling edge after release.
    task automatic do_reset();
        rst_n  = 1'b0;
        sync   = 1'b0;
        en     = '0;
        load   = 1'b0;
        ch_sel = '0;
        div    = '0;
        b_en   = '0;
        b_load = 1'b0;
        b_sel  = '0;
        b_div  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests++;
        if (out !== 4'b0000 || pend !== 4'b0000) begin
            fails++;
            $display("FAIL reset_assert out=%b pend=%b exp 0000/0000", out, pend);
        end
        do_reset();
        tests++;
        if (out !== 4'b0000 || pend !== 4'b0000 || b_out !== 3'b000 || b_pend !== 3'b000) begin
            fails++;
            $display("FAIL reset_release out=%b pend=%b b_out=%b b_pend=%b exp all zero",
                     out, pend, b_out, b_pend);
        end
    endtask

    // Default D=3 on ch0: pulses after edges 4, 8, 12.
    task automatic test_basic();
        logic [3:0] exp;
        do_reset();
        en[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp = (k % 4 == 0) ? 4'b0001 : 4'b0000;
            tests++;
            if (out !== exp) begin
                fails++;
                $display("FAIL basic k=%0d out=%b exp=%b", k, out, exp);
            end
        end
    endtask

    // ch1 reload to D=9 mid-period; ch0 keeps its 4-cycle phase.
    task automatic test_reload();
        logic [3:0] exp_out;
        logic [3:0] exp_pend;
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            if (k == 1) en = 4'b0011;
            if (k == 3) begin
                load = 1'b1; ch_sel = 2'd1; div = 32'd9;
            end
            if (k == 4) load = 1'b0;
            tick();
            exp_out  = {2'b00, (k == 4 || k == 14 || k == 24), (k % 4 == 0)};
            exp_pend = (k == 3) ? 4'b0010 : 4'b0000;
            tests++;
            if (out !== exp_out || pend !== exp_pend) begin
                fails++;
                $display("FAIL reload k=%0d out=%b pend=%b exp out=%b pend=%b",
                         k, out, pend, exp_out, exp_pend);
            end
        end
    endtask

    // D=0 on ch2: tick every cycle while enabled, drops the edge after disable.
    task automatic test_div_zero();
        logic [3:0] exp_out;
        logic [3:0] exp_pend;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            if (k == 1) begin
                load = 1'b1; ch_sel = 2'd2; div = 32'd0;
            end
            if (k == 2) load = 1'b0;
            if (k == 3) en[2] = 1'b1;
            if (k == 9) en[2] = 1'b0;
            tick();
            exp_out  = (k >= 3 && k <= 8) ? 4'b0100 : 4'b0000;
            exp_pend = (k == 1) ? 4'b0100 : 4'b0000;
            tests++;
            if (out !== exp_out || pend !== exp_pend) begin
                fails++;
                $display("FAIL div_zero k=%0d out=%b pend=%b exp out=%b pend=%b",
                         k, out, pend, exp_out, exp_pend);
            end
        end
    endtask

    // Two loads (5 then 7) before ch3 wraps: only D=7 takes effect, period 8.
    task automatic test_back_to_back();
        logic [3:0] exp_out;
        logic [3:0] exp_pend;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            if (k == 1) en[3] = 1'b1;
            if (k == 2) begin
                load = 1'b1; ch_sel = 2'd3; div = 32'd5;
            end
            if (k == 3) div = 32'd7;
            if (k == 4) load = 1'b0;
            tick();
            exp_out  = (k == 4 || k == 12 || k == 20) ? 4'b1000 : 4'b0000;
            exp_pend = (k == 2 || k == 3) ? 4'b1000 : 4'b0000;
            tests++;
            if (out !== exp_out || pend !== exp_pend) begin
                fails++;
                $display("FAIL back_to_back k=%0d out=%b pend=%b exp out=%b pend=%b",
                         k, out, pend, exp_out, exp_pend);
            end
        end
    endtask

    // 3-channel 4-bit instance: select 3 is out of range and must be ignored;
    // then D=15 (all ones) on ch1 gives a 16-cycle period.
    task automatic test_range_and_max();
        logic [2:0] exp_out;
        logic [2:0] exp_pend;
        do_reset();
        for (int k = 1; k <= 42; k++) begin
            if (k == 1) b_en[0] = 1'b1;
            if (k == 2) begin
                b_load = 1'b1; b_sel = 2'd3; b_div = 4'd0;
            end
            if (k == 3) b_load = 1'b0;
            if (k == 9) begin
                b_load = 1'b1; b_sel = 2'd1; b_div = 4'd15;
            end
            if (k == 10) b_load = 1'b0;
            if (k == 11) b_en[1] = 1'b1;
            tick();
            exp_out  = {1'b0, (k == 26 || k == 42), (k % 4 == 0)};
            exp_pend = (k == 9) ? 3'b010 : 3'b000;
            tests++;
            if (b_out !== exp_out || b_pend !== exp_pend) begin
                fails++;
                $display("FAIL range_max k=%0d out=%b pend=%b exp out=%b pend=%b",
                         k, b_out, b_pend, exp_out, exp_pend);
            end
        end
    endtask

    // Async reset mid-period with a load pending: outputs clear at once and
    // the pending D=9 is discarded, so the period is back to 4.
    task automatic test_reset_mid();
        logic [3:0] exp;
        do_reset();
        en[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                load = 1'b1; ch_sel = 2'd0; div = 32'd9;
            end
            tick();
        end
        load = 1'b0;
        tests++;
        if (out !== 4'b0001 || pend !== 4'b0001) begin
            fails++;
            $display("FAIL reset_mid_pre out=%b pend=%b exp 0001/0001", out, pend);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out !== 4'b0000 || pend !== 4'b0000) begin
            fails++;
            $display("FAIL reset_mid_async out=%b pend=%b exp 0000/0000", out, pend);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = (k % 4 == 0) ? 4'b0001 : 4'b0000;
            tests++;
            if (out !== exp || pend !== 4'b0000) begin
                fails++;
                $display("FAIL reset_mid_after k=%0d out=%b pend=%b exp out=%b pend=0000",
                         k, out, pend, exp);
            end
        end
    endtask

`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
    // ch0/ch1 at D=4 started two cycles apart; a sync pulse aligns them.
    task automatic test_sync();
        logic [3:0] exp;
        logic       aligned;
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            if (k == 1) begin
                load = 1'b1; ch_sel = 2'd0; div = 32'd4;
            end
            if (k == 2) ch_sel = 2'd1;
            if (k == 3) load = 1'b0;
            if (k == 4) en[0] = 1'b1;
            if (k == 6) en[1] = 1'b1;
            if (k == 10) sync = 1'b1;
            if (k == 11) sync = 1'b0;
            tick();
            aligned = (k == 15 || k == 20 || k == 25);
            exp = {2'b00, aligned, (aligned || k == 8)};
            if (k >= 4) begin
                tests++;
                if (out !== exp) begin
                    fails++;
                    $display("FAIL sync k=%0d out=%b exp=%b", k, out, exp);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_reload();
        test_div_zero();
        test_back_to_back();
        test_range_and_max();
        test_reset_mid();
`ifdef CLOCK_DIVIDER_PHASE_SYNC_EN
        test_sync();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
